// File: rtl/de1_soc_pio_pkg.sv
// Shared constants for the DE1-SoC Avalon-MM PIO peripherals.
// Covers the register word offsets, the edge-qualification encodings and the per-bit edge select helper.
package de1_soc_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Any encoding other than rise/fall is treated as "either edge".
  function automatic logic edge_event(input logic rise, input logic fall, input int edgeType);
    logic ev;
    case (edgeType)
      EDGE_RISE: ev = rise;
      EDGE_FALL: ev = fall;
      default:   ev = rise | fall;
    endcase
    return ev;
  endfunction

endpackage

// File: rtl/de1_soc_debounce.sv
// Single-bit two-flop synchronizer followed by a counting debouncer.
// A new level is accepted only after it has been seen for DEBOUNCE_CYCLES consecutive synchronized clocks.
module de1_soc_debounce #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;

  // Synchronizer flops reset to the idle level so release never looks like a transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable <= RESET_LEVEL;
      r_cnt    <= '0;
    end else if (r_sync2 == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;

endmodule

// File: rtl/de1_soc_key_pio.sv
// Avalon-MM input PIO for DE1-SoC keys/switches: debounced DATA, edge capture and a maskable level irq.
// Register reads are zero-wait-state and decoded from the address alone.
module de1_soc_key_pio
  import de1_soc_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_TYPE       = EDGE_FALL,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clear;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;
  logic             w_write;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    de1_soc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_VALUE[gi])
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .i_raw   (in_port[gi]),
      .o_stable(w_stable[gi])
    );
  end

  if (WIDTH < 32) begin : g_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata[31:WIDTH];
  end

  assign w_write = chipselect & ~write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stable_d <= RESET_VALUE;
    end else begin
      r_stable_d <= w_stable;
    end
  end

  always_comb begin
    w_event = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_event[i] = edge_event(w_stable[i] & ~r_stable_d[i],
                              ~w_stable[i] & r_stable_d[i], EDGE_TYPE);
    end
  end

  assign w_clear = (w_write && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= '0;
    end else if (w_write && address == ADDR_IRQMASK) begin
      r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  // A capture event arriving with a clear write wins, so no edge is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clear) | w_event;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = w_stable;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgecap;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_de1_soc_key_pio.sv
// Scoreboard bench for de1_soc_key_pio: a falling-edge and an any-edge instance share one bus.
// Stimulus queues expected read/irq values; a negedge monitor pops and compares them.
module tb_de1_soc_key_pio;
  import de1_soc_pio_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  typedef struct {
    string       name;
    bit          sel;
    logic [31:0] expData;
    bit          chkIrq;
    logic        expIrq;
  } exp_t;

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      rdFall;
  logic [31:0]      rdAny;
  logic             irqFall;
  logic             irqAny;

  exp_t expQ[$];
  int   assertCount = 0;
  int   failCount   = 0;

  de1_soc_key_pio #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(EDGE_FALL)) dutFall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdFall), .irq(irqFall)
  );

  de1_soc_key_pio #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .EDGE_TYPE(EDGE_ANY)) dutAny (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdAny), .irq(irqAny)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the bus for the cycle following the current posedge.
  task automatic applyStimulus(input logic [1:0] addr, input logic wr, input logic [31:0] wdata);
    address    = addr;
    chipselect = wr;
    write_n    = ~wr;
    writedata  = wdata;
  endtask

  // Queue the value the monitor must see at the coming negedge.
  task automatic checkOutput(input string name, input bit sel, input logic [31:0] expData,
                             input bit chkIrq, input logic expIrq);
    exp_t e;
    e.name    = name;
    e.sel     = sel;
    e.expData = expData;
    e.chkIrq  = chkIrq;
    e.expIrq  = expIrq;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      exp_t e;
      logic [31:0] rd;
      logic        ir;
      e  = expQ.pop_front();
      rd = e.sel ? rdAny : rdFall;
      ir = e.sel ? irqAny : irqFall;
      assertCount++;
      if (rd !== e.expData) begin
        failCount++;
        $display("[TB] FAIL %s: readdata got 0x%08h want 0x%08h", e.name, rd, e.expData);
      end
      if (e.chkIrq) begin
        assertCount++;
        if (ir !== e.expIrq) begin
          failCount++;
          $display("[TB] FAIL %s: irq got %0b want %0b", e.name, ir, e.expIrq);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b1;
    in_port = 4'hF;
    applyStimulus(ADDR_DATA, 1'b0, 32'h0);
    #2 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    $display("[TB] reset state");
    applyStimulus(ADDR_DATA, 1'b0, 32'h0);    checkOutput("rstData", 0, 32'hF, 1, 1'b0);
    tick(); applyStimulus(ADDR_RSVD, 1'b0, 32'h0);    checkOutput("rstRsvd", 0, 32'h0, 1, 1'b0);
    tick(); applyStimulus(ADDR_IRQMASK, 1'b0, 32'h0); checkOutput("rstMask", 0, 32'h0, 1, 1'b0);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); checkOutput("rstCap", 0, 32'h0, 1, 1'b0);
    tick(); applyStimulus(ADDR_DATA, 1'b1, 32'h0);
    tick(); applyStimulus(ADDR_RSVD, 1'b1, 32'hF);
    repeat (8) tick();
    applyStimulus(ADDR_DATA, 1'b0, 32'h0);    checkOutput("dataWriteIgnored", 0, 32'hF, 0, 1'b0);
    tick(); applyStimulus(ADDR_RSVD, 1'b0, 32'h0);    checkOutput("rsvdWriteIgnored", 0, 32'h0, 0, 1'b0);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); checkOutput("noEdgeOnRelease", 0, 32'h0, 1, 1'b0);
    checkOutput("noEdgeOnReleaseAny", 1, 32'h0, 1, 1'b0);

    $display("[TB] press bit 0");
    tick(); in_port = 4'hE;
    repeat (5) tick();
    applyStimulus(ADDR_DATA, 1'b0, 32'h0); checkOutput("dataBeforeAccept", 0, 32'hF, 1, 1'b0);
    tick(); checkOutput("dataAccept", 0, 32'hE, 1, 1'b0);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); checkOutput("capFall", 0, 32'h1, 1, 1'b0);
    tick(); applyStimulus(ADDR_IRQMASK, 1'b1, 32'h1); checkOutput("maskBeforeWrite", 0, 32'h0, 1, 1'b0);
    tick(); applyStimulus(ADDR_IRQMASK, 1'b0, 32'h0); checkOutput("irqAfterMask", 0, 32'h1, 1, 1'b1);

    $display("[TB] release, clear, set-wins");
    tick(); in_port = 4'hF;
    repeat (10) tick();
    applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); checkOutput("riseIgnored", 0, 32'h1, 1, 1'b1);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b1, 32'h1); checkOutput("clearCycle", 0, 32'h1, 1, 1'b1);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); checkOutput("clearWrite", 0, 32'h0, 1, 1'b0);
    tick(); in_port = 4'hE;
    repeat (6) tick();
    applyStimulus(ADDR_EDGECAP, 1'b1, 32'h1); checkOutput("capBeforeEvent", 0, 32'h0, 1, 1'b0);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); checkOutput("setWins", 0, 32'h1, 1, 1'b1);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b1, 32'h1); checkOutput("setWinsHold", 0, 32'h1, 1, 1'b1);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); checkOutput("clearAfterSetWins", 0, 32'h0, 1, 1'b0);

    $display("[TB] glitch on bit 1");
    tick(); in_port = 4'hC;
    repeat (3) tick();
    in_port = 4'hE;
    repeat (10) tick();
    applyStimulus(ADDR_DATA, 1'b0, 32'h0); checkOutput("glitchData", 0, 32'hE, 1, 1'b0);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); checkOutput("glitchCap", 0, 32'h0, 1, 1'b0);

    $display("[TB] any-edge instance");
    tick(); in_port = 4'hF;
    repeat (10) tick();
    applyStimulus(ADDR_EDGECAP, 1'b1, 32'hF);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); checkOutput("anyClear", 1, 32'h0, 1, 1'b0);
    tick(); in_port = 4'hB;
    repeat (10) tick();
    checkOutput("anyPress", 1, 32'h4, 1, 1'b0);
    checkOutput("fallPress", 0, 32'h4, 1, 1'b0);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b1, 32'hF);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); in_port = 4'hF;
    repeat (10) tick();
    checkOutput("anyRelease", 1, 32'h4, 1, 1'b0);
    checkOutput("fallReleaseIgnored", 0, 32'h0, 1, 1'b0);
    tick(); applyStimulus(ADDR_IRQMASK, 1'b1, 32'hFFFF_FFFF);
    tick(); applyStimulus(ADDR_IRQMASK, 1'b0, 32'h0);
    checkOutput("anyMaskAll", 1, 32'hF, 1, 1'b1);
    checkOutput("fallMaskAll", 0, 32'hF, 1, 1'b0);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b1, 32'hF);
    tick(); applyStimulus(ADDR_DATA, 1'b0, 32'h0);

    $display("[TB] reset mid-debounce");
    tick(); in_port = 4'h7;
    repeat (4) tick();
    reset_n = 1'b0;
    applyStimulus(ADDR_DATA, 1'b0, 32'h0); checkOutput("rstMidData", 0, 32'hF, 1, 1'b0);
    tick(); applyStimulus(ADDR_IRQMASK, 1'b0, 32'h0); checkOutput("rstMidMask", 0, 32'h0, 1, 1'b0);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); checkOutput("rstMidCap", 1, 32'h0, 1, 1'b0);
    tick(); reset_n = 1'b1;
    repeat (5) tick();
    applyStimulus(ADDR_DATA, 1'b0, 32'h0); checkOutput("rstNoEarlyData", 0, 32'hF, 1, 1'b0);
    tick(); applyStimulus(ADDR_EDGECAP, 1'b0, 32'h0); checkOutput("rstNoEarlyCap", 0, 32'h0, 1, 1'b0);
    tick(); checkOutput("capAfterFullInterval", 0, 32'h8, 1, 1'b0);
    tick(); applyStimulus(ADDR_DATA, 1'b0, 32'h0); checkOutput("dataAfterFullInterval", 0, 32'h7, 1, 1'b0);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() > 0) begin
      failCount++;
      $display("[TB] FAIL drain: pending checks got %0d want 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
